// File: rtl/timer_pkg.sv
// Shared types and APB width constants for the timer APB requester.
package timer_pkg;

  localparam int unsigned APB_ADDR_W = 12;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic                    write;
    logic [APB_ADDR_W-1:0]   addr;
    logic [APB_DATA_W-1:0]   wdata;
    logic [APB_DATA_W/8-1:0] strb;
  } req_t;

endpackage

// File: rtl/timer_apb_master.sv
// APB4 requester: valid/ready command stream in, one APB transfer out, response channel back.
// Optional access-phase watchdog enabled by defining TIMER_APB_MASTER_TIMEOUT_EN.
module timer_apb_master
  import timer_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                tim_psel,
  output logic                tim_penable,
  output logic                tim_pwrite,
  output logic [ADDR_W-1:0]   tim_paddr,
  output logic [DATA_W-1:0]   tim_pwdata,
  output logic [DATA_W/8-1:0] tim_pstrb,
  input  logic [DATA_W-1:0]   tim_prdata,
  input  logic                tim_pready,
  input  logic                tim_pslverr
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t            state, state_nxt;
  req_t              req;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              timed_out;

`ifdef TIMER_APB_MASTER_TIMEOUT_EN
  logic [7:0] wait_cnt;

  // Counter is held at zero outside ACCESS, so it is clear on every ACCESS entry.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      wait_cnt <= '0;
    else if (state != ACCESS)
      wait_cnt <= '0;
    else if (!tim_pready)
      wait_cnt <= wait_cnt + 8'd1;
  end

  assign timed_out = (state == ACCESS) && !tim_pready &&
                     (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    tim_psel    = 1'b0;
    tim_penable = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP: begin
        tim_psel  = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        tim_psel    = 1'b1;
        tim_penable = 1'b1;
        if (tim_pready || timed_out) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      req     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        req.write <= cmd_write;
        req.addr  <= cmd_addr;
        req.wdata <= cmd_wdata;
        req.strb  <= cmd_strb;
      end
      if (state == ACCESS) begin
        if (tim_pready) begin
          err_q   <= tim_pslverr;
          rdata_q <= (!req.write && !tim_pslverr) ? tim_prdata : '0;
        end else if (timed_out) begin
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
      end
    end
  end

  assign tim_pwrite = req.write;
  assign tim_paddr  = req.addr;
  assign tim_pwdata = req.write ? req.wdata : '0;
  assign tim_pstrb  = req.write ? req.strb : '0;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_timer_apb_master.sv
// Randomized self-checking bench for timer_apb_master with a timeline-based transfer model.
module tb_timer_apb_master;

`ifdef TIMER_APB_MASTER_TIMEOUT_EN
  localparam int unsigned TO    = 4;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned TO    = 16;
  localparam bit          TO_EN = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic        tim_psel, tim_penable, tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] tim_prdata = '0;
  logic        tim_pready = 1'b0, tim_pslverr = 1'b0;

  timer_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(tim_prdata), .tim_pready(tim_pready), .tim_pslverr(tim_pslverr)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model of the transfer in flight: everything follows from the handshake edge,
  // the number of access-phase cycles, and what the slave returns.
  bit          txn_active = 1'b0;
  int unsigned hs_cyc;
  bit          m_wr, m_err, m_to;
  logic [11:0] m_addr;
  logic [31:0] m_wdata, m_rd;
  logic [3:0]  m_strb;
  int unsigned m_len;
  bit          seen_rsp;
  int unsigned first_rsp_s;
  logic [31:0] cap_rdata;
  logic        cap_err;
  int unsigned last_hs_wait;

  logic [11:0] nx_addr;
  logic [31:0] nx_wdata;
  logic [3:0]  nx_strb;
  bit          nx_wr;

  always @(negedge sys_clk) begin
    int unsigned s;
    logic [31:0] exp_rd;
    logic        exp_err;
    if (txn_active) begin
      s       = cyc - hs_cyc + 1;
      exp_err = m_to ? 1'b1 : m_err;
      exp_rd  = (m_to || m_wr || m_err) ? 32'h0 : m_rd;
      chk("cmd_ready_busy", cmd_ready, 0);
      if (s <= 1 + m_len) begin
        chk("psel", tim_psel, 1);
        chk("penable", tim_penable, (s >= 2) ? 1 : 0);
        chk("rsp_valid_early", rsp_valid, 0);
        chk("paddr", tim_paddr, m_addr);
        chk("pwrite", tim_pwrite, m_wr);
        chk("pwdata", tim_pwdata, m_wr ? m_wdata : 32'h0);
        chk("pstrb", tim_pstrb, m_wr ? m_strb : 4'h0);
      end else begin
        chk("psel_resp", tim_psel, 0);
        chk("penable_resp", tim_penable, 0);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        if (!seen_rsp) begin
          seen_rsp    = 1'b1;
          first_rsp_s = s;
          cap_rdata   = rsp_rdata;
          cap_err     = rsp_err;
        end
      end
    end else begin
      chk("cmd_ready_idle", cmd_ready, 1);
      chk("psel_idle", tim_psel, 0);
      chk("penable_idle", tim_penable, 0);
      chk("rsp_valid_idle", rsp_valid, 0);
    end
  end

  // Called #1 after a rising edge. w = wait states (large value = slave never ready).
  task automatic run_txn(input bit wr, input logic [11:0] a, input logic [31:0] d,
                         input logic [3:0] st, input int unsigned w, input logic [31:0] rd,
                         input bit err, input int unsigned rdly, input bit early,
                         input int unsigned rst_at);
    int unsigned n, s, len;
    bit hs, done, in_resp, to;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = st;
    n = 0; hs = 1'b0;
    while (!hs) begin
      @(negedge sys_clk); hs = cmd_ready;
      @(posedge sys_clk); #1;
      if (!hs) begin
        n++;
        if (n > 20) begin
          chk("cmd_accept_bound", 0, 1);
          cmd_valid = 1'b0;
          return;
        end
      end
    end
    last_hs_wait = n;
    to  = TO_EN && (w + 1 > TO);
    len = to ? TO : w + 1;
    m_wr = wr; m_addr = a; m_wdata = d; m_strb = st; m_rd = rd; m_err = err;
    m_to = to; m_len = len; seen_rsp = 1'b0; hs_cyc = cyc; txn_active = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = 12'($urandom);
    cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    done = 1'b0; s = 1;
    while (!done) begin
      if (rst_at != 0 && s == rst_at) begin
        #2 sys_rst = 1'b1; txn_active = 1'b0;
        #1;
        chk("rst_psel", tim_psel, 0);
        chk("rst_penable", tim_penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        tim_pready = 1'b0; rsp_ready = 1'b0;
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        return;
      end
      in_resp    = (s >= 2 + len);
      tim_pready = !to && (s == 1 + len);
      if (tim_pready) begin
        tim_prdata = rd; tim_pslverr = err;
      end else begin
        tim_prdata = $urandom; tim_pslverr = 1'($urandom);
      end
      if (in_resp) begin
        rsp_ready = (s - (2 + len) >= rdly);
        if (early) begin
          cmd_valid = 1'b1; cmd_write = nx_wr; cmd_addr = nx_addr;
          cmd_wdata = nx_wdata; cmd_strb = nx_strb;
        end
      end else begin
        rsp_ready = 1'($urandom);
      end
      @(posedge sys_clk); #1;
      if (in_resp && rsp_ready) done = 1'b1;
      s++;
      if (!done && s > len + rdly + 10) begin
        chk("txn_bound", 0, 1);
        done = 1'b1;
      end
    end
    txn_active = 1'b0; rsp_ready = 1'b0; tim_pready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_psel", tim_psel, 0);
    chk("reset_penable", tim_penable, 0);
    chk("reset_pwrite", tim_pwrite, 0);
    chk("reset_paddr", tim_paddr, 0);
    chk("reset_pwdata", tim_pwdata, 0);
    chk("reset_pstrb", tim_pstrb, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    chk("reset_rsp_err", rsp_err, 0);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;

    run_txn(1, 12'h004, 32'hA5A5_0001, 4'hF, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    chk("t1_rsp_at", first_rsp_s, 3);
    chk("t1_err", cap_err, 0);
    chk("t1_rdata", cap_rdata, 32'h0);

    run_txn(0, 12'h008, 32'h5555_AAAA, 4'hF, 3, 32'h1234_5678, 0, 0, 0, 0);
    chk("t2_rsp_at", first_rsp_s, 6);
    chk("t2_rdata", cap_rdata, 32'h1234_5678);

    run_txn(0, 12'h00C, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 1, 1, 0, 0);
    chk("t3_err", cap_err, 1);
    chk("t3_rdata", cap_rdata, 32'h0);

    nx_wr = 1'b0; nx_addr = 12'h010; nx_wdata = 32'h0; nx_strb = 4'h3;
    run_txn(1, 12'h014, 32'hCAFE_F00D, 4'h5, 0, 32'h0, 0, 5, 1, 0);
    run_txn(0, 12'h010, 32'h0, 4'h3, 2, 32'h0BAD_CAFE, 0, 0, 0, 0);
    chk("t4_next_accept", last_hs_wait, 0);
    chk("t4_rdata", cap_rdata, 32'h0BAD_CAFE);

    run_txn(1, 12'h020, 32'h1111_2222, 4'hF, 6, 32'h0, 0, 0, 0, 3);
    @(negedge sys_clk);
    chk("t5_cmd_ready_after", cmd_ready, 1);
    @(posedge sys_clk); #1;
    run_txn(0, 12'h024, 32'h0, 4'h0, 0, 32'h7777_0001, 0, 0, 0, 5);
    run_txn(0, 12'h028, 32'h0, 4'h0, 0, 32'h7777_0002, 0, 0, 0, 0);
    chk("t5_recover_rdata", cap_rdata, 32'h7777_0002);

`ifdef TIMER_APB_MASTER_TIMEOUT_EN
    run_txn(0, 12'h030, 32'h0, 4'h0, 1000, 32'h9999_9999, 0, 1, 0, 0);
    chk("to_rsp_at", first_rsp_s, 6);
    chk("to_err", cap_err, 1);
    chk("to_rdata", cap_rdata, 32'h0);
    run_txn(0, 12'h034, 32'h0, 4'h0, 3, 32'h4444_3333, 0, 0, 0, 0);
    chk("to_edge_rsp_at", first_rsp_s, 6);
    chk("to_edge_err", cap_err, 0);
    chk("to_edge_rdata", cap_rdata, 32'h4444_3333);
`endif

    for (int i = 0; i < 60; i++) begin
      int unsigned w;
      w = $urandom_range(0, 6);
      if (TO_EN && $urandom_range(0, 4) == 0) w = 1000;
      run_txn(1'($urandom), 12'($urandom), $urandom, 4'($urandom), w, $urandom,
              ($urandom_range(0, 3) == 0), $urandom_range(0, 3), 0, 0);
    end

    repeat (2) @(posedge sys_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
